pwm_sample_scheduler: RTL and testbench
=======================================

// Module: pwm_sample_scheduler
// PURPOSE
//  Sequences the PWM output stage. Accepts mixed samples from the mixer via valid/ready,
//  buffers them in a small FIFO, and hands exactly one sample per PWM period to the PWM block
//  (mixed_sample/en), so the duty cycle only changes on period boundaries.
//  Sits between the voice mixer and pwm; owns pwm's enable.
// PARAMETERS
//  WIDTH         8    sample width; must equal the pwm counter width
//  FIFO_DEPTH    4    sample FIFO entries; power of 2, >= 2
//  PRIME_LEVEL   2    FIFO entries required before playback starts; 1..FIFO_DEPTH
//  PERIOD_CYCLES 256  clocks per PWM period; must match the pwm counter wrap; >= 2
// PORTS
//  clk           in   1           system clock, all logic on rising edge
//  rst           in   1           asynchronous reset, active-high
//  start         in   1           1-cycle pulse: begin playback and clear underrun
//  stop          in   1           1-cycle pulse: end playback at the end of the current period
//  in_sample     in   WIDTH       sample from the mixer
//  in_valid      in   1           in_sample is valid
//  in_ready      out  1           FIFO accepts; a push happens when in_valid & in_ready
//  mixed_sample  out  WIDTH       sample to pwm, registered
//  pwm_en        out  1           enable to pwm, registered
//  period_strobe out  1           1-cycle pulse on the cycle a new sample is loaded
//  underrun      out  1           sticky: FIFO was empty at a period boundary
//  fifo_count    out  clog2(D)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset (async, when rst=1):
//   - state=IDLE, FIFO empty, period_cnt=0, mixed_sample=0, pwm_en=0
//   - period_strobe=0, underrun=0
//  in_ready:
//   - = !full, from the registered count; 0 in STOPPING
//   - A push on the same cycle as a pop while full is not possible; a push and pop together
//     when not full leave the count unchanged
//  FSM states and transitions:
//   IDLE:
//    - pwm_en=0, mixed_sample=0
//    - start -> PRIME, and clear underrun
//    - stop is ignored
//   PRIME:
//    - pwm_en=0
//    - when fifo_count >= PRIME_LEVEL -> RUN; on that same edge:
//      pop head into mixed_sample, pwm_en<=1, period_cnt<=0, period_strobe<=1
//    - stop -> IDLE, flush FIFO (stop takes priority)
//   RUN:
//    - period_cnt counts 0..PERIOD_CYCLES-1 and wraps
//    - on the edge leaving period_cnt==PERIOD_CYCLES-1, one of:
//      - FIFO non-empty: pop into mixed_sample, period_strobe<=1
//      - FIFO empty: hold mixed_sample, underrun<=1, period_strobe<=1
//    - stop (registered as stop_pending) -> STOPPING
//    - start is ignored
//   STOPPING:
//    - same as RUN, but no pop at the period end
//    - on the edge leaving period_cnt==PERIOD_CYCLES-1 -> IDLE:
//      pwm_en<=0, mixed_sample<=0, FIFO flushed
//  Latency:
//   - new sample is visible on mixed_sample exactly PERIOD_CYCLES clocks after the previous one
//   - the first sample appears 1 clock after the PRIME condition is met
//  Simultaneous events:
//   - start and stop together: stop wins (IDLE stays IDLE)
//   - a push on the boundary cycle is not seen by that boundary's pop unless the FIFO was
//     non-empty before it
//  Reset mid-operation: all state is lost immediately; no partial period is completed
// TESTING (PERIOD_CYCLES=8, FIFO_DEPTH=4, PRIME_LEVEL=2 unless stated)
//  1. Assert rst with in_valid=1 and start=1
//     -> all outputs 0; in_ready=1 one cycle after rst falls; state IDLE
//  2. Push 10,20,30, then start
//     -> pwm_en=1 with mixed_sample=10 on the next clock;
//        mixed_sample 20 after 8 clocks, 30 after 16 clocks;
//        period_strobe pulses exactly at those three cycles
//  3. Continue case 2 with no more pushes
//     -> at the 24-clock boundary mixed_sample holds 30, underrun=1, sticky;
//        the next start clears it
//  4. Hold in_valid=1 with 5 distinct samples while in IDLE
//     -> 4 accepted, in_ready=0 and fifo_count=4; the 5th is accepted only after the first pop
//  5. In RUN, pulse stop at period_cnt=3
//     -> pwm_en stays 1 for 4 more clocks, then pwm_en=0, mixed_sample=0, fifo_count=0,
//        no pop at that boundary
//  6. Pulse rst at period_cnt=5 in RUN
//     -> outputs 0 immediately (async); after release a start with 2 pushes restarts
//        at period_cnt=0

Source files
------------

// File: rtl/pwm_sample_scheduler_if.sv
// Mixer-to-PWM scheduler bus: control pulses, sample handshake and PWM-side outputs.
// Handshake: a sample transfers on a rising clk edge where in_valid && in_ready are both 1;
// in_sample must be stable while in_valid is high, and in_ready never depends on in_valid.
// state_dbg encoding: 0=IDLE, 1=PRIME, 2=RUN, 3=STOPPING.
interface pwm_sample_scheduler_if #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic             start;
  logic             stop;
  logic [WIDTH-1:0] in_sample;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] mixed_sample;
  logic             pwm_en;
  logic             period_strobe;
  logic             underrun;
  logic [CW-1:0]    fifo_count;
  logic [1:0]       state_dbg;

  modport master (
    output start, stop, in_sample, in_valid,
    input  in_ready, mixed_sample, pwm_en, period_strobe, underrun, fifo_count, state_dbg
  );

  modport slave (
    input  start, stop, in_sample, in_valid,
    output in_ready, mixed_sample, pwm_en, period_strobe, underrun, fifo_count, state_dbg
  );
endinterface

// File: rtl/pwm_sample_scheduler.sv
// PWM sample scheduler: buffers mixer samples in a small FIFO and hands one sample to the
// PWM stage per PWM period, so the duty cycle only changes on period boundaries.
module pwm_sample_scheduler #(
  parameter int WIDTH         = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int PRIME_LEVEL   = 2,
  parameter int PERIOD_CYCLES = 256
) (
  input logic clk,
  input logic rst,
  pwm_sample_scheduler_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(PERIOD_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRIME    = 2'd1,
    ST_RUN      = 2'd2,
    ST_STOPPING = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_period_cnt;
  logic [WIDTH-1:0] r_mixed;
  logic             r_pwm_en;
  logic             r_strobe;
  logic             r_underrun;

  logic             w_full;
  logic             w_empty;
  logic             w_in_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_flush;
  logic             w_boundary;
  logic             w_prime_ok;
  logic [WIDTH-1:0] w_head;

  // Everything is decided from registered occupancy, so a push on a boundary cycle can
  // never feed that same boundary's pop.
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_in_ready = !w_full && (r_state != ST_STOPPING);
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_boundary = (r_period_cnt == PW'(PERIOD_CYCLES - 1));
  assign w_prime_ok = (r_count >= CW'(PRIME_LEVEL));
  assign w_head     = r_mem[r_rd_ptr];

  // Pop/flush requests derived from the current state and the period position.
  always_comb begin
    w_pop   = 1'b0;
    w_flush = 1'b0;
    case (r_state)
      ST_PRIME: begin
        if (bus.stop)        w_flush = 1'b1;
        else if (w_prime_ok) w_pop   = 1'b1;
      end
      ST_RUN:      if (w_boundary && !w_empty) w_pop = 1'b1;
      ST_STOPPING: if (w_boundary) w_flush = 1'b1;
      default: ;
    endcase
  end

  // Sample storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.in_sample;
  end

  // FIFO pointers and occupancy; a flush discards everything including a same-cycle push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Playback FSM with registered PWM-side outputs and the period counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_period_cnt <= '0;
      r_mixed      <= '0;
      r_pwm_en     <= 1'b0;
      r_strobe     <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_pwm_en <= 1'b0;
          r_mixed  <= '0;
          // stop beats start when both arrive together
          if (bus.start && !bus.stop) begin
            r_state    <= ST_PRIME;
            r_underrun <= 1'b0;
          end
        end
        ST_PRIME: begin
          r_pwm_en <= 1'b0;
          if (bus.stop) begin
            r_state <= ST_IDLE;
          end else if (w_prime_ok) begin
            r_state      <= ST_RUN;
            r_mixed      <= w_head;
            r_pwm_en     <= 1'b1;
            r_period_cnt <= '0;
            r_strobe     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_boundary) begin
            r_period_cnt <= '0;
            r_strobe     <= 1'b1;
            if (!w_empty) r_mixed    <= w_head;
            else          r_underrun <= 1'b1;
          end else begin
            r_period_cnt <= r_period_cnt + PW'(1);
          end
          if (bus.stop) r_state <= ST_STOPPING;
        end
        ST_STOPPING: begin
          // finish the current period, then shut the PWM off without loading a sample
          if (w_boundary) begin
            r_period_cnt <= '0;
            r_state      <= ST_IDLE;
            r_pwm_en     <= 1'b0;
            r_mixed      <= '0;
          end else begin
            r_period_cnt <= r_period_cnt + PW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.mixed_sample  = r_mixed;
  assign bus.pwm_en        = r_pwm_en;
  assign bus.period_strobe = r_strobe;
  assign bus.underrun      = r_underrun;
  assign bus.fifo_count    = r_count;
  assign bus.state_dbg     = r_state;
endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// Bench for pwm_sample_scheduler: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based playback model.
module tb_pwm_sample_scheduler;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int PL = 2;
  localparam int P  = 8;

  localparam int M_IDLE  = 0;
  localparam int M_PRIME = 1;
  localparam int M_PLAY  = 2;
  localparam int M_DRAIN = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pwm_sample_scheduler_if #(.WIDTH(W), .FIFO_DEPTH(D)) bus();

  pwm_sample_scheduler #(
    .WIDTH(W), .FIFO_DEPTH(D), .PRIME_LEVEL(PL), .PERIOD_CYCLES(P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: a sample queue, a play mode and the age of the sample on the output
  logic [W-1:0] exp_q[$];
  int           mode     = M_IDLE;
  int           age      = 0;
  logic [W-1:0] e_out    = '0;
  bit           e_en     = 1'b0;
  bit           e_strobe = 1'b0;
  bit           e_under  = 1'b0;
  int           m_n;
  bit           m_push;
  bit           m_flush;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      exp_q.delete();
      mode = M_IDLE; age = 0; e_out = '0; e_en = 0; e_strobe = 0; e_under = 0;
    end else begin
      m_n     = exp_q.size();
      m_push  = bus.in_valid && (m_n < D) && (mode != M_DRAIN);
      m_flush = 1'b0;
      e_strobe = 1'b0;
      case (mode)
        M_IDLE: begin
          if (bus.start && !bus.stop) begin mode = M_PRIME; e_under = 1'b0; end
        end
        M_PRIME: begin
          if (bus.stop) begin mode = M_IDLE; m_flush = 1'b1; end
          else if (m_n >= PL) begin
            e_out = exp_q.pop_front(); e_en = 1'b1; age = 0; e_strobe = 1'b1; mode = M_PLAY;
          end
        end
        M_PLAY: begin
          if (age == P - 1) begin
            age = 0; e_strobe = 1'b1;
            if (m_n > 0) e_out = exp_q.pop_front();
            else         e_under = 1'b1;
          end else age++;
          if (bus.stop) mode = M_DRAIN;
        end
        default: begin
          if (age == P - 1) begin
            age = 0; mode = M_IDLE; e_en = 1'b0; e_out = '0; m_flush = 1'b1;
          end else age++;
        end
      endcase
      if (m_flush) exp_q.delete();
      else if (m_push) exp_q.push_back(bus.in_sample);
    end
  end

  // scoreboard compare, every cycle, just after the outputs settle
  initial forever begin
    @(posedge clk);
    #2;
    if (cmp_en) begin
      chk("mixed_sample",  bus.mixed_sample,  e_out);
      chk("pwm_en",        bus.pwm_en,        e_en);
      chk("period_strobe", bus.period_strobe, e_strobe);
      chk("underrun",      bus.underrun,      e_under);
      chk("fifo_count",    bus.fifo_count,    exp_q.size());
      chk("in_ready",      bus.in_ready,      (exp_q.size() < D) && (mode != M_DRAIN));
    end
  end

  // driver tasks (inputs change on the falling edge)
  task automatic send(input logic [W-1:0] d, output int waits);
    bit rdy;
    bit done;
    bus.in_valid  = 1'b1;
    bus.in_sample = d;
    waits = 0;
    done  = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      rdy = bus.in_ready;
      @(negedge clk);
      if (rdy) done = 1'b1;
      else     waits++;
    end
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1; @(negedge clk); bus.stop = 1'b0;
  endtask

  task automatic wait_strobe();
    int k = 0;
    while (!bus.period_strobe && k < 40) begin @(negedge clk); k++; end
    chk("strobe_seen", 32'(k < 40), 1);
  endtask

  task automatic wait_pwm_off();
    int k = 0;
    while (bus.pwm_en && k < 40) begin @(negedge clk); k++; end
    chk("pwm_off_seen", 32'(k < 40), 1);
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  int w;
  int pct;

  initial begin
    bus.start = 1'b1; bus.stop = 1'b0; bus.in_valid = 1'b1; bus.in_sample = 8'h55;

    // 1. reset held with in_valid and start asserted
    repeat (3) @(negedge clk);
    chk("rst_mixed",  bus.mixed_sample, 0);
    chk("rst_pwm_en", bus.pwm_en, 0);
    chk("rst_strobe", bus.period_strobe, 0);
    chk("rst_under",  bus.underrun, 0);
    chk("rst_count",  bus.fifo_count, 0);
    rst = 1'b0; bus.in_valid = 1'b0; bus.start = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", bus.in_ready, 1);
    chk("post_rst_state", bus.state_dbg, 0);

    // 2. three samples then start
    send(8'd10, w); send(8'd20, w); send(8'd30, w);
    bus.in_valid = 1'b0;
    pulse_start();
    @(posedge clk); #2;
    chk("first_sample", bus.mixed_sample, 10);
    chk("first_en",     bus.pwm_en, 1);
    chk("first_strobe", bus.period_strobe, 1);
    repeat (P - 1) @(posedge clk);
    #2;
    chk("mid_period_strobe", bus.period_strobe, 0);
    @(posedge clk); #2;
    chk("second_sample", bus.mixed_sample, 20);
    chk("second_strobe", bus.period_strobe, 1);
    repeat (P) @(posedge clk);
    #2;
    chk("third_sample", bus.mixed_sample, 30);
    chk("third_strobe", bus.period_strobe, 1);

    // 3. starve the FIFO: underrun, sticky, cleared by the next start
    repeat (P) @(posedge clk);
    #2;
    chk("underrun_hold", bus.mixed_sample, 30);
    chk("underrun_set",  bus.underrun, 1);
    chk("underrun_strb", bus.period_strobe, 1);
    repeat (P) @(posedge clk);
    #2;
    chk("underrun_sticky", bus.underrun, 1);
    @(negedge clk);
    pulse_stop();
    wait_pwm_off();
    pulse_start();
    chk("underrun_cleared", bus.underrun, 0);
    pulse_stop();
    @(negedge clk);

    // 4. fill the FIFO while idle; the 5th sample waits for the first pop
    for (int i = 0; i < D; i++) send(8'(100 + i), w);
    chk("fill_count", bus.fifo_count, 4);
    chk("fill_ready", bus.in_ready, 0);
    bus.in_sample = 8'd104;
    pulse_start();
    send(8'd104, w);
    bus.in_valid = 1'b0;
    chk("fifth_waits",  w, 1);
    chk("fifth_head",   bus.mixed_sample, 100);
    chk("fifth_count",  bus.fifo_count, 4);

    // 5. stop at period_cnt=3
    wait_strobe();
    repeat (3) @(negedge clk);
    pulse_stop();
    for (int i = 0; i < 4; i++) begin
      chk("stopping_en", bus.pwm_en, 1);
      @(negedge clk);
    end
    chk("stopped_en",    bus.pwm_en, 0);
    chk("stopped_mixed", bus.mixed_sample, 0);
    chk("stopped_count", bus.fifo_count, 0);

    // 6. reset in the middle of a period, then restart
    send(8'h11, w); send(8'h22, w);
    bus.in_valid = 1'b0;
    pulse_start();
    wait_strobe();
    chk("pre_rst_sample", bus.mixed_sample, 8'h11);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_en",    bus.pwm_en, 0);
    chk("async_rst_mixed", bus.mixed_sample, 0);
    chk("async_rst_count", bus.fifo_count, 0);
    @(negedge clk);
    rst = 1'b0;
    send(8'h33, w); send(8'h44, w);
    bus.in_valid = 1'b0;
    pulse_start();
    @(posedge clk); #2;
    chk("restart_sample", bus.mixed_sample, 8'h33);
    chk("restart_strobe", bus.period_strobe, 1);
    repeat (P) @(posedge clk);
    #2;
    chk("restart_second", bus.mixed_sample, 8'h44);
    @(negedge clk);

    // 7. randomized traffic, control pulses and occasional resets
    pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) pct = $urandom_range(0, 40);
      bus.in_valid  = ($urandom_range(0, 99) < pct);
      bus.in_sample = 8'($urandom_range(0, 255));
      bus.start     = ($urandom_range(0, 29) == 0);
      bus.stop      = ($urandom_range(0, 119) == 0);
      rst           = ($urandom_range(0, 999) == 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
